alu_issue_stage: RTL
====================

# alu_issue_stage

Issue stage that produces operand and control traffic for the registered ALU. It accepts decoded RV32I instruction fields from the ID stage over a valid/ready handshake, then resolves operand A/B selection and the 4-bit ALU control code. The results are registered toward the EX-stage ALU, with backpressure and pipeline flush. It is the producing end of the ALU's A/B/ALUcontrol interface.

## Interface
- TAG_W, default 5: width of the destination-register tag carried alongside the operation.
- XLEN, default 32: operand width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discards all held entries (branch mispredict/trap).
- in_valid  in  1  ID offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_opcode  in  7  instruction[6:0].
- in_funct3  in  3  instruction[14:12].
- in_funct7_5  in  1  instruction[30].
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_pc  in  XLEN  instruction address.
- in_tag  in  TAG_W  rd index.
- out_valid  out  1  operation presented to EX.
- out_ready  in  1  EX consumes this cycle.
- out_a, out_b  out  XLEN  ALU operands.
- out_alu_ctrl  out  4  ALU control code.
- out_illegal  out  1  opcode/funct combination not executable on the ALU.
- out_tag  out  TAG_W  rd index.

## Operation
- ALU control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, NOP 1111.
- OP (0110011), B=rs2: funct3 000 gives ADD, or SUB when funct7_5=1. 100 gives XOR, 110 OR, 111 AND, 001 SLL. 101 gives SRL, or SRA when funct7_5=1.
- OP-IMM (0010011), B=imm: same mapping as OP. funct7_5 is honoured only for funct3=101; ADDI never becomes SUB.
- Shifts (OP and OP-IMM): out_b = {27'b0, shamt[4:0]}. The shift amount is masked here because the ALU shifts by the full B value.
- LOAD (0000011) and STORE (0100011): ADD, A=rs1, B=imm.
- BRANCH (1100011): SUB, A=rs1, B=rs2. EX uses the ALU zero flag.
- LUI (0110111): ADD, A=0, B=imm.
- AUIPC (0010111): ADD, A=pc, B=imm.
- SLT/SLTU (funct3 010/011) and any other opcode: out_alu_ctrl=1111, out_illegal=1, operands zero. The entry still flows through the pipeline.
- Handshake:
  - A transfer occurs when valid and ready are both high at a clock edge.
  - out_valid and all out_* fields stay stable while out_valid=1 and out_ready=0.
- Flush:
  - On the edge where flush=1, every held entry is invalidated.
  - Any simultaneous input acceptance is dropped; flush wins.
  - in_ready is unaffected.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid=0, out_a=0, out_b=0, out_alu_ctrl=1111, out_illegal=0, out_tag=0, skid entry empty.
- Latency: an instruction accepted at edge N appears on out_* after edge N, i.e. one cycle.
- Throughput: one per cycle while out_ready=1.
- Output register empty and in_valid=1: the instruction is captured regardless of out_ready.
- Simultaneous out transfer and in accept: the output register is reloaded with the new entry, with no bubble.
- Reset mid-stream: every in-flight entry is lost. No handshake is required.

## Configuration
- ALU_ISSUE_SKID_EN defined:
  - Adds a one-entry skid buffer behind the output register.
  - in_ready = skid empty, driven from a flop, with no combinational path from out_ready.
  - When out is stalled and an input is accepted, the input goes to the skid entry.
  - The skid entry moves to the output register on the next out transfer.
  - Order is preserved.
- Undefined:
  - Single register.
  - in_ready = !out_valid || out_ready, a combinational path.

## Structure
- Shared package alu_pkg holds:
  - the ALU control code constants (ALU_AND … ALU_SRA, ALU_NOP);
  - the opcode constants;
  - a packed issue_entry_t {a, b, alu_ctrl, illegal, tag}.
- Combinational sub-module alu_ctrl_decode maps opcode/funct fields, rs data, imm and pc to an issue_entry_t. The top level holds the handshake, skid and flush logic.

## Test plan
- ADD rs1=5, rs2=7, funct7_5=0 → next cycle out_a=5, out_b=7, ctrl=0010, out_valid=1.
- SRAI imm=0x400_0423 (funct7_5=1, shamt=3), funct3=101 → ctrl=0111, out_b=3.
- BEQ rs1=rs2=0x1234 → ctrl=0110, out_a=out_b=0x1234. SLTI → ctrl=1111, illegal=1.
- Hold out_ready=0 for 4 cycles while sending 3 back-to-back instructions:
  - SKID_EN: in_ready drops after 2 accepts; outputs stay stable; release gives entries 1, 2, 3 in order.
  - No SKID_EN: in_ready drops after 1 accept.
- Raise flush in the same cycle as an input accept while the output is valid → out_valid=0 next cycle, and the accepted entry never appears.
- Assert rst_n=0 asynchronously mid-stall → out_valid=0 and out_alu_ctrl=1111 immediately, before the next clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: control codes, RV32I opcodes and
// the registered issue entry handed to the EX-stage ALU.
package alu_pkg;

  localparam int ISSUE_XLEN  = 32;
  localparam int ISSUE_TAG_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [ISSUE_XLEN-1:0]  a;
    logic [ISSUE_XLEN-1:0]  b;
    logic [3:0]             alu_ctrl;
    logic                   illegal;
    logic [ISSUE_TAG_W-1:0] tag;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET = '{a: '0, b: '0, alu_ctrl: ALU_NOP, illegal: 1'b0, tag: '0};

  // funct3 -> ALU code for OP/OP-IMM; SLT/SLTU have no ALU code and map to NOP.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] funct3,
                                            input logic       sub_sel,
                                            input logic       sra_sel);
    logic [3:0] code;
    code = ALU_NOP;
    case (funct3)
      3'b000:  code = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b100:  code = ALU_XOR;
      3'b101:  code = sra_sel ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// ID->issue->EX channel bundle; slave is the issue stage, master is its environment.
interface alu_issue_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic             in_funct7_5;
  logic [XLEN-1:0]  in_rs1_data;
  logic [XLEN-1:0]  in_rs2_data;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_pc;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_a;
  logic [XLEN-1:0]  out_b;
  logic [3:0]       out_alu_ctrl;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_tag, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_tag, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I field decode into ALU operands, control code and illegal flag.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic [TAG_W-1:0] tag,
  output issue_entry_t     entry
);

  logic             is_shift;
  logic [XLEN-1:0]  shamt_rs2;
  logic [XLEN-1:0]  shamt_imm;
  logic [3:0]       op_ctrl;
  logic [3:0]       opi_ctrl;

  // The ALU shifts by the whole B value, so only the 5-bit shamt may reach it.
  assign is_shift  = (funct3[1:0] == 2'b01);
  assign shamt_rs2 = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
  assign shamt_imm = {{(XLEN-5){1'b0}}, imm[4:0]};
  assign op_ctrl   = arith_ctrl(funct3, funct7_5, funct7_5);
  assign opi_ctrl  = arith_ctrl(funct3, 1'b0, funct7_5);

  always_comb begin
    entry = '{a: '0, b: '0, alu_ctrl: ALU_NOP, illegal: 1'b1, tag: tag};
    case (opcode)
      OPC_OP: begin
        if (op_ctrl != ALU_NOP) begin
          entry.a        = rs1_data;
          entry.b        = is_shift ? shamt_rs2 : rs2_data;
          entry.alu_ctrl = op_ctrl;
          entry.illegal  = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if (opi_ctrl != ALU_NOP) begin
          entry.a        = rs1_data;
          entry.b        = is_shift ? shamt_imm : imm;
          entry.alu_ctrl = opi_ctrl;
          entry.illegal  = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        entry.a        = rs1_data;
        entry.b        = imm;
        entry.alu_ctrl = ALU_ADD;
        entry.illegal  = 1'b0;
      end
      OPC_BRANCH: begin
        entry.a        = rs1_data;
        entry.b        = rs2_data;
        entry.alu_ctrl = ALU_SUB;
        entry.illegal  = 1'b0;
      end
      OPC_LUI: begin
        entry.b        = imm;
        entry.alu_ctrl = ALU_ADD;
        entry.illegal  = 1'b0;
      end
      OPC_AUIPC: begin
        entry.a        = pc;
        entry.b        = imm;
        entry.alu_ctrl = ALU_ADD;
        entry.illegal  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage toward the EX ALU with valid/ready, flush and backpressure.
// Define ALU_ISSUE_SKID_EN for a one-entry skid buffer and a registered in_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_issue_if.slave io
);

  issue_entry_t dec_ent_p0;
  issue_entry_t out_ent_p1;
  logic         vld_p1;
  logic         in_fire;
  logic         out_fire;

  alu_ctrl_decode #(.XLEN(XLEN), .TAG_W(TAG_W)) u_decode (
    .opcode   (io.in_opcode),
    .funct3   (io.in_funct3),
    .funct7_5 (io.in_funct7_5),
    .rs1_data (io.in_rs1_data),
    .rs2_data (io.in_rs2_data),
    .imm      (io.in_imm),
    .pc       (io.in_pc),
    .tag      (io.in_tag),
    .entry    (dec_ent_p0)
  );

  assign out_fire = vld_p1 && io.out_ready;

  // ---- p0 -> p1: output register (and optional skid entry)
`ifdef ALU_ISSUE_SKID_EN
  issue_entry_t skid_ent_p1;
  logic         skid_vld_p1;

  assign io.in_ready = !skid_vld_p1;
  assign in_fire     = io.in_valid && !skid_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_ent_p1  <= ENTRY_RESET;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || out_fire) begin
      // Skid entry is always older than anything on the input, so it goes first.
      if (skid_vld_p1) begin
        out_ent_p1  <= skid_ent_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (in_fire) begin
        out_ent_p1 <= dec_ent_p0;
        vld_p1     <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) skid_ent_p1 <= dec_ent_p0;
  end
`else
  assign io.in_ready = !vld_p1 || io.out_ready;
  assign in_fire     = io.in_valid && io.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      out_ent_p1 <= ENTRY_RESET;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1     <= 1'b1;
      out_ent_p1 <= dec_ent_p0;
    end else if (out_fire) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

  assign io.out_valid    = vld_p1;
  assign io.out_a        = out_ent_p1.a;
  assign io.out_b        = out_ent_p1.b;
  assign io.out_alu_ctrl = out_ent_p1.alu_ctrl;
  assign io.out_illegal  = out_ent_p1.illegal;
  assign io.out_tag      = out_ent_p1.tag;

endmodule
